// File: rtl/input_logic.sv
// input_logic: front-panel input block that synchronizes switches, debounces ENTER/PEEK and hands captured words to the controller.
// Optional macro INPUT_DEBOUNCE_EN enables the DEB_CYCLES key debounce; without it keys are only synchronized and registered.
module input_logic #(
    parameter int DW         = 10,
    parameter int DEB_CYCLES = 500000
) (
    input  logic          CLK,
    input  logic          RSTb,
    input  logic [DW-1:0] SW,
    input  logic          KEY_ENTERb,
    input  logic          KEY_PEEKb,
    input  logic          ACCEPT,
    output logic [DW-1:0] DIN,
    output logic          EXTERN,
    output logic          PEEKb,
    output logic          BUSY
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } stateType;

    stateType      state;
    logic [DW-1:0] swSync1;
    logic [DW-1:0] swSync2;
    logic          enterSync1;
    logic          enterSync2;
    logic          peekSync1;
    logic          peekSync2;
    logic          enterStable;
    logic          peekStable;
    logic          enterPrev;
    logic          enterPress;
    logic          enterRelease;

    if (DEB_CYCLES < 2) begin : gDebCheck
        $error("input_logic: DEB_CYCLES must be at least 2");
    end

    // Two-flop synchronizers; keys reset to the released level so nothing looks pressed out of reset.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            swSync1    <= '0;
            swSync2    <= '0;
            enterSync1 <= 1'b1;
            enterSync2 <= 1'b1;
            peekSync1  <= 1'b1;
            peekSync2  <= 1'b1;
        end else begin
            swSync1    <= SW;
            swSync2    <= swSync1;
            enterSync1 <= KEY_ENTERb;
            enterSync2 <= enterSync1;
            peekSync1  <= KEY_PEEKb;
            peekSync2  <= peekSync1;
        end
    end

`ifdef INPUT_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] enterCount;
    logic [CW-1:0] peekCount;

    // A key level is accepted only after DEB_CYCLES consecutive cycles of disagreement with the current stable level.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            enterCount  <= '0;
            peekCount   <= '0;
            enterStable <= 1'b1;
            peekStable  <= 1'b1;
        end else begin
            if (enterSync2 == enterStable) begin
                enterCount <= '0;
            end else if (enterCount == DEB_LAST) begin
                enterStable <= enterSync2;
                enterCount  <= '0;
            end else begin
                enterCount <= enterCount + CW'(1);
            end

            if (peekSync2 == peekStable) begin
                peekCount <= '0;
            end else if (peekCount == DEB_LAST) begin
                peekStable <= peekSync2;
                peekCount  <= '0;
            end else begin
                peekCount <= peekCount + CW'(1);
            end
        end
    end
`else
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            enterStable <= 1'b1;
            peekStable  <= 1'b1;
        end else begin
            enterStable <= enterSync2;
            peekStable  <= peekSync2;
        end
    end
`endif

    assign PEEKb        = peekStable;
    assign enterPress   = enterPrev & ~enterStable;
    assign enterRelease = ~enterPrev & enterStable;

    // Capture handshake: one word per press, held until ACCEPT, then wait for the key to come back up.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state     <= IDLE;
            DIN       <= '0;
            EXTERN    <= 1'b0;
            BUSY      <= 1'b0;
            enterPrev <= 1'b1;
        end else begin
            enterPrev <= enterStable;
            case (state)
                IDLE: begin
                    if (enterPress) begin
                        DIN    <= swSync2;
                        EXTERN <= 1'b1;
                        BUSY   <= 1'b1;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (ACCEPT) begin
                        EXTERN <= 1'b0;
                        if (enterStable) begin
                            state <= IDLE;
                            BUSY  <= 1'b0;
                        end else begin
                            state <= WAIT_REL;
                        end
                    end
                end
                WAIT_REL: begin
                    if (enterRelease) begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    EXTERN <= 1'b0;
                    BUSY   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_logic.sv
// tb_input_logic: directed front-panel scenarios plus randomized key/switch/accept traffic against a behavioural model.
// Runs in either build; key latency follows INPUT_DEBOUNCE_EN.
module tb_input_logic;

    localparam int DW  = 10;
    localparam int DEB = 4;
`ifdef INPUT_DEBOUNCE_EN
    localparam int W = DEB;
    localparam logic [DW-1:0] DIN_AFTER_BOUNCE = 10'h2A5;
`else
    localparam int W = 1;
    localparam logic [DW-1:0] DIN_AFTER_BOUNCE = 10'h1FF;
`endif

    logic          CLK = 1'b0;
    logic          RSTb;
    logic [DW-1:0] SW;
    logic          KEY_ENTERb;
    logic          KEY_PEEKb;
    logic          ACCEPT;
    logic [DW-1:0] DIN;
    logic          EXTERN;
    logic          PEEKb;
    logic          BUSY;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    always #5 CLK = ~CLK;

    input_logic #(.DW(DW), .DEB_CYCLES(DEB)) dut (
        .CLK       (CLK),
        .RSTb      (RSTb),
        .SW        (SW),
        .KEY_ENTERb(KEY_ENTERb),
        .KEY_PEEKb (KEY_PEEKb),
        .ACCEPT    (ACCEPT),
        .DIN       (DIN),
        .EXTERN    (EXTERN),
        .PEEKb     (PEEKb),
        .BUSY      (BUSY)
    );

    task automatic checkOutput(input string tag, input logic [DW-1:0] eDin, input logic eExt,
                               input logic ePeek, input logic eBusy);
        checks += 4;
        if (DIN !== eDin) begin
            errors++;
            $display("[TB] FAIL %s.DIN got %h want %h at %0t", tag, DIN, eDin, $time);
        end
        if (EXTERN !== eExt) begin
            errors++;
            $display("[TB] FAIL %s.EXTERN got %b want %b at %0t", tag, EXTERN, eExt, $time);
        end
        if (PEEKb !== ePeek) begin
            errors++;
            $display("[TB] FAIL %s.PEEKb got %b want %b at %0t", tag, PEEKb, ePeek, $time);
        end
        if (BUSY !== eBusy) begin
            errors++;
            $display("[TB] FAIL %s.BUSY got %b want %b at %0t", tag, BUSY, eBusy, $time);
        end
    endtask

    task automatic applyStimulus(input logic rstb, input logic enter, input logic peek,
                                 input logic acc, input logic [DW-1:0] sw);
        @(negedge CLK);
        RSTb       = rstb;
        KEY_ENTERb = enter;
        KEY_PEEKb  = peek;
        ACCEPT     = acc;
        SW         = sw;
    endtask

    task automatic waitPosedges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Behavioural model: synced key = raw two edges ago; a key level flips once the last W synced samples all disagree with it.
    logic          m1E, m2E, m1P, m2P;
    logic [DW-1:0] m1S, m2S;
    logic          stE, stP, prevE;
    logic [7:0]    histE, histP;
    int            seenE, seenP;
    logic [DW-1:0] mDin;
    logic          mExtern, mBusy;

    function automatic logic settles(input logic [7:0] hist, input int seen, input logic st);
        if (seen < W) return 1'b0;
        for (int i = 0; i < W; i++) begin
            if (hist[i] == st) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge CLK) begin
        bit pressNow;
        bit releaseNow;
        if (!RSTb) begin
            m1E = 1'b1; m2E = 1'b1; m1P = 1'b1; m2P = 1'b1;
            m1S = '0;   m2S = '0;
            stE = 1'b1; stP = 1'b1; prevE = 1'b1;
            histE = '1; histP = '1; seenE = 0; seenP = 0;
            mDin = '0; mExtern = 1'b0; mBusy = 1'b0;
        end else begin
            pressNow   = prevE && !stE;
            releaseNow = !prevE && stE;
            if (!mBusy) begin
                if (pressNow) begin
                    mDin    = m2S;
                    mExtern = 1'b1;
                    mBusy   = 1'b1;
                end
            end else if (mExtern) begin
                if (ACCEPT) begin
                    mExtern = 1'b0;
                    mBusy   = !stE;
                end
            end else if (releaseNow) begin
                mBusy = 1'b0;
            end
            prevE = stE;
            histE = {histE[6:0], m2E};
            histP = {histP[6:0], m2P};
            if (seenE < W) seenE++;
            if (seenP < W) seenP++;
            if (settles(histE, seenE, stE)) stE = m2E;
            if (settles(histP, seenP, stP)) stP = m2P;
            m2E = m1E; m1E = KEY_ENTERb;
            m2P = m1P; m1P = KEY_PEEKb;
            m2S = m1S; m1S = SW;
        end
    end

    always @(negedge CLK) begin
        if (checking) checkOutput("model", mDin, mExtern, stP, mBusy);
    end

    initial begin
        logic          curEnter;
        logic          curPeek;
        logic [DW-1:0] curSw;

        RSTb = 1'b0; KEY_ENTERb = 1'b1; KEY_PEEKb = 1'b1; ACCEPT = 1'b0; SW = '0;
        waitPosedges(2);
        checkOutput("reset", '0, 1'b0, 1'b1, 1'b0);
        checking = 1'b1;

        $display("[TB] basic transfer");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h2A5);
        waitPosedges(2 + W);
        checkOutput("press-early", '0, 1'b0, 1'b1, 1'b0);
        waitPosedges(1);
        checkOutput("press", 10'h2A5, 1'b1, 1'b1, 1'b1);

        $display("[TB] ignore during hold");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h1FF);
        waitPosedges(10);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h1FF);
        waitPosedges(10);
        checkOutput("hold-ignore", 10'h2A5, 1'b1, 1'b1, 1'b1);

        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 10'h1FF);
        waitPosedges(1);
        checkOutput("accept", 10'h2A5, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h1FF);
        waitPosedges(2 + W);
        checkOutput("release-early", 10'h2A5, 1'b0, 1'b1, 1'b1);
        waitPosedges(1);
        checkOutput("release", 10'h2A5, 1'b0, 1'b1, 1'b0);

        $display("[TB] bounce");
        for (int r = 0; r < 5; r++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h1FF);
            waitPosedges(3);
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h1FF);
            waitPosedges(3);
`ifdef INPUT_DEBOUNCE_EN
            checkOutput("bounce", 10'h2A5, 1'b0, 1'b1, 1'b0);
`endif
        end
        waitPosedges(10);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'h1FF);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h1FF);
        waitPosedges(5);
        checkOutput("after-bounce", DIN_AFTER_BOUNCE, 1'b0, 1'b1, 1'b0);

        $display("[TB] peek");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'h1FF);
        waitPosedges(1 + W);
        checkOutput("peek-early", DIN_AFTER_BOUNCE, 1'b0, 1'b1, 1'b0);
        waitPosedges(1);
        checkOutput("peek", DIN_AFTER_BOUNCE, 1'b0, 1'b0, 1'b0);
        waitPosedges(10 - (2 + W));
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h1FF);
        waitPosedges(1 + W);
        checkOutput("unpeek-early", DIN_AFTER_BOUNCE, 1'b0, 1'b0, 1'b0);
        waitPosedges(1);
        checkOutput("unpeek", DIN_AFTER_BOUNCE, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset during hold");
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h155);
        waitPosedges(3 + W + 2);
        checkOutput("hold2", 10'h155, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'h0F0);
        waitPosedges(1);
        checkOutput("mid-reset", '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10'h0F0);
        waitPosedges(2 + W);
        checkOutput("repress-early", '0, 1'b0, 1'b1, 1'b0);
        waitPosedges(1);
        checkOutput("repress", 10'h0F0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'h0F0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10'h0F0);
        waitPosedges(10);
        checkOutput("cleanup", 10'h0F0, 1'b0, 1'b1, 1'b0);

        $display("[TB] random traffic");
        curEnter = 1'b1; curPeek = 1'b1; curSw = 10'h0F0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) curEnter = ~curEnter;
            if ($urandom_range(9) == 0) curPeek = ~curPeek;
            if ($urandom_range(3) == 0) curSw = DW'($urandom);
            applyStimulus(($urandom_range(399) != 0), curEnter, curPeek,
                          ($urandom_range(5) == 0), curSw);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, curSw);
        waitPosedges(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_logic.md
Name: input_logic

Overview:
- Front-panel input block for the bus-based processor; the input-side counterpart of the display/LED output logic.
- Synchronizes the 10 data switches and debounces two active-low push buttons (ENTER, PEEK).
- On an ENTER press, captures the switch word as the external data word and raises EXTERN to the controller until the controller acknowledges with ACCEPT.
- Provides the debounced PEEKb level that the output logic consumes.

Parameters:
DW, 10, data/switch width; matches bus width.
DEB_CYCLES, 500000, consecutive stable cycles required before a debounced key changes (10 ms at 50 MHz); minimum 2.

Ports:
CLK  in  1  system clock; everything is on the rising edge.
RSTb  in  1  reset, synchronous, active-low.
SW  in  DW  raw slide switches, asynchronous.
KEY_ENTERb  in  1  raw ENTER button, active-low, asynchronous.
KEY_PEEKb  in  1  raw PEEK button, active-low, asynchronous.
ACCEPT  in  1  controller has consumed DIN; single-cycle pulse, synchronous to CLK.
DIN  out  DW  captured data word to be driven onto the bus by the controller.
EXTERN  out  1  external data valid; held until ACCEPT.
PEEKb  out  1  debounced PEEK level, active-low; goes to the output logic.
BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (RSTb sampled low at a CLK edge)
  - DIN=0, EXTERN=0, PEEKb=1, BUSY=0, FSM=IDLE.
  - SW sync flops = 0; key sync flops = 1 (released).
  - Debounce counters = 0; debounced key levels = 1.
  - Reset asserted mid-operation aborts any transfer on that edge; nothing is retained.
- Synchronization
  - SW and both keys pass through 2-flop synchronizers before any other use.
  - DIN is loaded from the synchronized SW, never from the raw input.
- Debounce (per key)
  - Each key has a counter and a debounced level register `stable`.
  - Each cycle the synchronized value differs from `stable`, the counter increments.
  - When the counter reaches DEB_CYCLES-1 while the values still differ, `stable` takes the synchronized value and the counter clears.
  - Any cycle where the synchronized value equals `stable` clears the counter.
  - Total latency from a raw edge to a `stable` change is 2 + DEB_CYCLES cycles.
  - PEEKb is the registered `stable` level of the PEEK key.
- Press detect
  - The ENTER `stable` value is registered into `prev`.
  - press = prev & ~stable, a one-cycle pulse.
  - release = ~prev & stable.
- FSM
  - IDLE:
    - On press, load DIN <= synced SW, set EXTERN <= 1, go to HOLD.
    - EXTERN and DIN are visible on the edge after the press pulse.
    - ACCEPT is ignored in IDLE.
  - HOLD:
    - EXTERN stays 1 and DIN is frozen.
    - When ACCEPT is sampled 1, EXTERN <= 0 on that edge and the FSM goes to WAIT_REL.
    - If the ENTER `stable` level has already returned to 1 on the ACCEPT edge, the FSM goes directly to IDLE.
  - WAIT_REL:
    - On release, go to IDLE.
    - DIN holds its last value in both WAIT_REL and IDLE until the next press.
  - In HOLD and WAIT_REL, further presses and SW changes are ignored: there is no queueing and no overwrite.
  - BUSY = (state != IDLE), registered together with the state.
- Boundary conditions
  - A key held through reset release is treated as a new press once the debounce completes, because `stable` resets to released.
  - ACCEPT coincident with a press in IDLE: the press is taken and ACCEPT is ignored.
  - Bounces shorter than DEB_CYCLES never change `stable`.

Optional Feature:
INPUT_DEBOUNCE_EN
- Defined: debounce counters are present as described above.
- Undefined: counters are removed; `stable` is simply the synchronized key registered once (latency 3 cycles); DEB_CYCLES is unused.
- The FSM, synchronizers and reset values are identical in both builds.

Test Plan:
All scenarios use DEB_CYCLES=4 with INPUT_DEBOUNCE_EN defined unless noted.
1. Reset: RSTb low for 2 edges with keys released → DIN=0, EXTERN=0, PEEKb=1, BUSY=0.
2. Basic transfer: SW=10'h2A5, KEY_ENTERb low held → EXTERN=1 and DIN=10'h2A5 by 8 cycles after the key edge, BUSY=1. Then ACCEPT pulse → EXTERN=0 next edge, BUSY stays 1. Then key released → BUSY=0 by 7 cycles after release.
3. Bounce reject: KEY_ENTERb low for 3 cycles, then high, repeated 5 times → EXTERN never asserts and BUSY stays 0.
4. Ignore during HOLD: after the 10'h2A5 capture, set SW=10'h1FF and release/re-press ENTER without ACCEPT → DIN stays 10'h2A5 and EXTERN stays 1.
5. PEEK: KEY_PEEKb low for 10 cycles → PEEKb=0 exactly 6 cycles after the edge. Release → PEEKb=1 six cycles later. DIN and EXTERN are unaffected.
6. Reset mid-HOLD while ENTER is still held → next edge EXTERN=0, DIN=0, BUSY=0. After RSTb high, a new press is detected and EXTERN=1 with DIN=synced SW. Repeat with INPUT_DEBOUNCE_EN undefined → press latency is 4 cycles.
